// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor. Computes in_a - in_b - bin one bit per
//   clock, LSB first, using a single full-subtractor cell and a borrow flop.
//   A start/busy/done handshake frames each operation. Results are registered
//   and held until the next operation completes.
//
// Ports
//   sys_clk : system clock, rising edge
//   sys_rst : synchronous active-high reset
//   start   : begin an operation (sampled only while idle)
//   in_a    : minuend, captured on the accepting edge
//   in_b    : subtrahend, captured on the accepting edge
//   bin     : borrow-in, captured on the accepting edge
//   busy    : high while bits are being processed
//   done    : one-cycle pulse when diff/bout/ovf become valid
//   diff    : (in_a - in_b - bin) mod 2^WIDTH
//   bout    : borrow-out (unsigned result negative)
//   ovf     : two's-complement signed overflow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    // Full-subtractor cell on the current LSBs
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        d_bit    = a_sr[0] ^ b_sr[0] ^ br;
        br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_next = {d_bit, r_sr[WIDTH-1:1]};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= in_a;
                        b_sr  <= in_b;
                        br    <= bin;
                        cnt   <= '0;
                        a_msb <= in_a[WIDTH-1];
                        b_msb <= in_b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    r_sr <= res_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // d_bit is the result MSB on the final bit
                        diff  <= res_next;
                        bout  <= br_next;
                        ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes in_a - in_b - bin one bit per clock, LSB first, with a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the combinational full_adder and is used where area matters more than latency.
- Start/busy/done handshake; results are registered and held until the next operation.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 2.

Ports:
- sys_clk, input, 1, system clock; all logic is on the rising edge.
- sys_rst, input, 1, synchronous active-high reset.
- start, input, 1, request to begin an operation; sampled only in IDLE.
- in_a, input, WIDTH, minuend; captured on the accepting edge.
- in_b, input, WIDTH, subtrahend; captured on the accepting edge.
- bin, input, 1, borrow-in; captured on the accepting edge.
- busy, output, 1, high while bits are being processed.
- done, output, 1, one-cycle pulse when diff/bout/ovf become valid.
- diff, output, WIDTH, difference (in_a - in_b - bin) mod 2^WIDTH.
- bout, output, 1, borrow-out (1 when the unsigned result is negative).
- ovf, output, 1, two's-complement signed overflow.

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst, and it has priority over everything else.
- Reset values: state = IDLE; busy, done, diff, bout and ovf = 0; internal shift registers, borrow flop and bit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: occurs on an edge where start = 1. On that edge:
  - a_sr <= in_a, b_sr <= in_b, br <= bin.
  - cnt <= 0, busy <= 1.
  - Latch a_msb = in_a[WIDTH-1] and b_msb = in_b[WIDTH-1] for the overflow calculation.
- RUN: on each edge, one bit is processed.
  - Difference bit: d = a_sr[0] ^ b_sr[0] ^ br.
  - Borrow: br <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - a_sr and b_sr shift right by one.
  - The result register shifts right, with d entering at bit WIDTH-1.
  - cnt increments.
- RUN -> DONE: on the edge that processes bit WIDTH-1. On that edge:
  - diff <= final result register.
  - bout <= final borrow.
  - ovf <= (a_msb != b_msb) && (result MSB != a_msb).
  - busy <= 0, done <= 1.
- DONE -> IDLE: unconditional on the next edge; done <= 0.
- Latency: if start is accepted at edge 0, done is high for exactly one cycle after edge WIDTH. That is WIDTH cycles of busy, then 1 cycle of done.
- diff, bout and ovf change only on the RUN->DONE edge or on reset. They hold their values through IDLE and through the next operation until that operation completes.
- start while in RUN or DONE: ignored, with no queuing. start is re-sampled once back in IDLE.
- start held high continuously: back-to-back operations, one accepted every WIDTH+2 cycles (IDLE, WIDTH x RUN, DONE).
- Input changes: in_a, in_b and bin may change freely after the accepting edge without affecting the operation in progress.
- Reset during RUN or DONE: the operation is aborted. Outputs return to reset values on that edge and no done pulse is produced.
- Implementation budget: the bit counter is $clog2(WIDTH) bits wide, and there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with in_a=8'd100, in_b=8'd37, bin=0 -> busy high for 8 cycles; done pulses one cycle after edge 8; diff=8'd63, bout=0, ovf=0.
- in_a=8'h00, in_b=8'h01, bin=0 -> diff=8'hFF, bout=1, ovf=0. in_a=8'h80, in_b=8'h01 -> diff=8'h7F, bout=0, ovf=1.
- in_a=8'd5, in_b=8'd5, bin=1 -> diff=8'hFF, bout=1, ovf=0. A following operation 8'h7F-8'hFF, bin=0 -> diff=8'h80, bout=1, ovf=1.
- Pulse start again at cycle 3 of RUN with different operands -> ignored; first result unchanged; exactly one done pulse.
- Assert sys_rst at cycle 4 of RUN -> next edge: busy=0, done=0, diff=0, bout=0, ovf=0; no done pulse; a new start afterwards completes correctly.
- Hold start high with random in_a/in_b/bin (bench randomizes at each acceptance) for 200 operations -> each done: {bout,diff} == ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1); ovf matches the signed check; done spacing is exactly 10 cycles.
